d_ff: RTL and testbench
=======================

D_FF -- requirements
Module: d_ff

Interface
REQ-001 Parameter WIDTH, default 1: number of independent flip-flop bits.
REQ-002 Parameter INIT, default all-zeros (WIDTH bits): value loaded into q on reset.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge only.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port d, input, WIDTH bits: data input.
REQ-006 Port q, output, WIDTH bits: registered data output.
REQ-007 Port qn, output, WIDTH bits: complement of q; present only when D_FF_QN_EN is defined.
REQ-008 Positional port order SHALL be clk, d, q, rst, then qn when compiled in, so that 3-port positional instances (clk, d, q) remain legal.

Function
REQ-009 Each bit SHALL be built as a JK flip-flop core driven through a D-to-JK conversion: J = d[i], K = ~d[i].
REQ-010 The JK core SHALL implement the full JK table on the rising clk edge: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
REQ-011 Through the conversion only the set and clear rows are reachable, so q[i] SHALL equal d[i] sampled at the previous rising clk edge.
REQ-012 Latency SHALL be exactly one clk rising edge from d to q; q SHALL be stable between edges regardless of d activity.
REQ-013 Bits SHALL be independent; no cross-bit interaction for any WIDTH >= 1.
REQ-014 With no reset applied since power-up, q SHALL be unknown until the first rising clk edge, then follow REQ-011.
REQ-015 A change of d coincident with a rising clk edge SHALL be treated as arriving after that edge and captured at the next edge; the bench SHALL avoid driving d on the edge.
REQ-016 qn, when present, SHALL be the combinational complement of q at all times, including during reset.

Reset
REQ-017 When rst = 1 at a rising clk edge, q SHALL load INIT, overriding the JK inputs.
REQ-018 rst has priority over d; an rst pulse shorter than one clock period that does not span a rising edge SHALL have no effect.
REQ-019 On the first rising edge with rst = 0 after reset, q SHALL capture d.
REQ-020 An unconnected rst (high-Z or X) SHALL be treated as deasserted, so 3-port instances behave as a plain D flip-flop.

Configuration
REQ-021 Macro D_FF_QN_EN: when defined, port qn exists and is driven per REQ-016.
REQ-022 Without D_FF_QN_EN, qn SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-023 Plain capture, WIDTH=1, rst=0, clk period 10 ns: d=0 at t=0, 1 at t=17, 0 at t=27, 1 at t=37, 0 at t=47 -> q=0 after the 5 ns edge, 1 after 25, 0 after 35, 1 after 45, 0 after 55.
REQ-024 Reset priority: q=1, d=1, rst=1 over one rising edge -> q=0 (INIT); rst=0 at the next edge with d=1 -> q=1.
REQ-025 Between-edge stability: q=0, then d toggles three times between two rising edges and ends at 1 -> q stays 0 until the next edge, then becomes 1.
REQ-026 Multi-bit with custom INIT: WIDTH=8, INIT=8'hA5, assert rst -> q=8'hA5; then d=8'h3C -> q=8'h3C one edge later.
REQ-027 Complement output: with D_FF_QN_EN defined, drive d through 0,1,0 -> qn equals ~q after every edge and during reset (qn=~INIT).
REQ-028 Unconnected reset: 3-port positional instance (clk, d, q) with d=1 -> q=1 after the first rising edge.

Source files
------------

// File: rtl/d_ff.sv
// d_ff: WIDTH-bit D flip-flop; each bit is a JK core fed through a D-to-JK conversion.
// Optional complement output qn is compiled in when D_FF_QN_EN is defined.
module d_ff #(
   parameter int unsigned      WIDTH = 1,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   // Defaulted low so a 3-port (clk, d, q) instance acts as a plain D flip-flop.
   input  logic             rst = 1'b0
`ifdef D_FF_QN_EN
   ,
   output logic [WIDTH-1:0] qn
`endif
);

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_CLEAR  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_e;

   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;

   // D-to-JK conversion: only the set and clear rows of the JK table are reachable.
   assign w_j = d;
   assign w_k = ~d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_op_e w_op;
      logic   r_bit;

      assign w_op = jk_op_e'({w_j[i], w_k[i]});

      // NOTE: state is updated with non-blocking assignments so every bit samples
      // pre-edge values; an X/Z rst fails the if-test and falls through to the JK path.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_bit <= INIT[i];
         end else begin
            case (w_op)
               JK_HOLD:   r_bit <= r_bit;
               JK_CLEAR:  r_bit <= 1'b0;
               JK_SET:    r_bit <= 1'b1;
               JK_TOGGLE: r_bit <= ~r_bit;
               default:   r_bit <= r_bit;
            endcase
         end
      end

      assign q[i] = r_bit;
   end

`ifdef D_FF_QN_EN
   assign qn = ~q;
`endif

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: table-driven check of a 1-bit and an 8-bit (INIT=A5) d_ff, plus hand-written
// sequences for between-edge stability, short reset pulses and a 3-port positional instance.
module tb_d_ff;

   logic       clk = 1'b0;
   logic       rst1, d1, q1;
   logic       rst8;
   logic [7:0] d8, q8;
   logic       d3, q3;
`ifdef D_FF_QN_EN
   logic       qn1;
   logic [7:0] qn8;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   d_ff u_one (
      .clk (clk),
      .d   (d1),
      .q   (q1),
      .rst (rst1)
`ifdef D_FF_QN_EN
      ,
      .qn  (qn1)
`endif
   );

   d_ff #(.WIDTH(8), .INIT(8'hA5)) u_byte (
      .clk (clk),
      .d   (d8),
      .q   (q8),
      .rst (rst8)
`ifdef D_FF_QN_EN
      ,
      .qn  (qn8)
`endif
   );

   // Reset left unconnected on purpose.
   d_ff u_plain (clk, d3, q3);

   typedef struct {
      logic       rst1;
      logic       d1;
      logic       exp1;
      logic       rst8;
      logic [7:0] d8;
      logic [7:0] exp8;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      // {rst1, d1, exp q1, rst8, d8, exp q8}
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hA5};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 8'hC3};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 8'h80};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, 8'hA5};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 8'h0F};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5};

      rst1 = 1'b1; d1 = 1'b0;
      rst8 = 1'b1; d8 = 8'h00;
      d3   = 1'b1;

      // Plain instance captures d on the very first edge.
      @(posedge clk); #1;
      check("plain_first_edge", {7'd0, q3}, 8'h01);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rst1 = vecs[i].rst1; d1 = vecs[i].d1;
         rst8 = vecs[i].rst8; d8 = vecs[i].d8;
         d3   = vecs[i].d1;
`ifdef D_FF_QN_EN
         #1;
         if (rst8) check($sformatf("qn8_in_reset_%0d", i), qn8, ~q8);
`endif
         @(posedge clk); #1;
         check($sformatf("q1_vec%0d", i), {7'd0, q1}, {7'd0, vecs[i].exp1});
         check($sformatf("q8_vec%0d", i), q8, vecs[i].exp8);
         check($sformatf("plain_vec%0d", i), {7'd0, q3}, {7'd0, vecs[i].d1});
`ifdef D_FF_QN_EN
         check($sformatf("qn1_vec%0d", i), {7'd0, qn1}, {7'd0, ~vecs[i].exp1});
         check($sformatf("qn8_vec%0d", i), qn8, ~vecs[i].exp8);
`endif
      end

      // Plain capture timing: d changes 2 ns after each rising edge.
      rst1 = 1'b0;
      #1; d1 = 1'b1;
      @(posedge clk); #1; check("cap_rise", {7'd0, q1}, 8'h01);
      #1; d1 = 1'b0;
      @(posedge clk); #1; check("cap_fall", {7'd0, q1}, 8'h00);

      // Between-edge stability: d toggles three times, ends at 1.
      #1; d1 = 1'b1;
      #1; d1 = 1'b0;
      #1; d1 = 1'b1;
      #2; check("stable_mid", {7'd0, q1}, 8'h00);
      d8 = 8'hFF;
      #1; d8 = 8'h00;
      #1; check("stable_mid8", q8, 8'hA5);
      @(posedge clk); #1; check("stable_after", {7'd0, q1}, 8'h01);
      check("stable_after8", q8, 8'h00);

      // Reset pulse that does not span a rising edge has no effect.
      #1; rst1 = 1'b1; rst8 = 1'b1;
      #3; rst1 = 1'b0; rst8 = 1'b0;
      d8 = 8'h96;
      @(posedge clk); #1;
      check("short_rst_q1", {7'd0, q1}, 8'h01);
      check("short_rst_q8", q8, 8'h96);

      // Reset priority with d equal to current q, then release captures d.
      #1; rst1 = 1'b1; d1 = 1'b1; rst8 = 1'b1; d8 = 8'h96;
      @(posedge clk); #1;
      check("rst_prio_q1", {7'd0, q1}, 8'h00);
      check("rst_prio_q8", q8, 8'hA5);
      #1; rst1 = 1'b0; rst8 = 1'b0;
      @(posedge clk); #1;
      check("rst_release_q1", {7'd0, q1}, 8'h01);
      check("rst_release_q8", q8, 8'h96);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
